// File: rtl/fc_ctrl.sv
// rtl/fc_ctrl.sv - FC classifier sequencer: clear, feed N pooled features, wait for class, report done/irq
// Optional WAIT timeout enabled by defining FC_CTRL_TIMEOUT_EN.
module fc_ctrl #(
    parameter int I_BW        = 16,
    parameter int I_SIZE      = 4,
    parameter int CI          = 12,
    parameter int TIMEOUT_CYC = 64,
    localparam int N          = I_SIZE * I_SIZE * CI,
    localparam int ADDR_BW    = $clog2(N)
) (
    input  logic               clk,
    input  logic               global_rst_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_done_clr,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_irq,
    output logic [3:0]         o_result,
    output logic               o_timeout,
    output logic               o_buf_rd_en,
    output logic [ADDR_BW-1:0] o_buf_addr,
    input  logic [I_BW-1:0]    i_buf_rd_data,
    output logic               o_fc_ce,
    output logic [I_BW-1:0]    o_fc_data,
    output logic               o_fc_user_reset,
    input  logic               i_fc_end,
    input  logic [3:0]         i_fc_data
);

    localparam logic [ADDR_BW:0] CNT_N = (ADDR_BW + 1)'(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state;
    logic [ADDR_BW:0]   rd_cnt;
    logic [ADDR_BW:0]   ce_cnt;
    logic               rd_vld;

`ifdef FC_CTRL_TIMEOUT_EN
    localparam int WAIT_BW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [WAIT_BW-1:0] WAIT_LAST = WAIT_BW'(TIMEOUT_CYC - 1);
    logic [WAIT_BW-1:0] wait_cnt;
`endif

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state           <= S_IDLE;
            rd_cnt          <= '0;
            ce_cnt          <= '0;
            rd_vld          <= 1'b0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_irq           <= 1'b0;
            o_result        <= 4'h0;
            o_timeout       <= 1'b0;
            o_buf_rd_en     <= 1'b0;
            o_buf_addr      <= '0;
            o_fc_ce         <= 1'b0;
            o_fc_data       <= '0;
            o_fc_user_reset <= 1'b0;
`ifdef FC_CTRL_TIMEOUT_EN
            wait_cnt        <= '0;
`endif
        end else begin
            o_irq           <= 1'b0;
            o_fc_user_reset <= 1'b0;
            if (state != S_IDLE && i_abort) begin
                // Abort drops in-flight read data and clears the datapath; done/result are left alone
                state           <= S_IDLE;
                o_fc_user_reset <= 1'b1;
                o_buf_rd_en     <= 1'b0;
                rd_vld          <= 1'b0;
                o_fc_ce         <= 1'b0;
                o_busy          <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_start) begin
                            state           <= S_CLEAR;
                            o_busy          <= 1'b1;
                            o_done          <= 1'b0;
                            o_timeout       <= 1'b0;
                            o_fc_user_reset <= 1'b1;
                            rd_cnt          <= '0;
                            ce_cnt          <= '0;
                            rd_vld          <= 1'b0;
                        end else if (i_done_clr) begin
                            o_done    <= 1'b0;
                            o_timeout <= 1'b0;
                        end
                    end
                    S_CLEAR, S_FEED: begin
                        state <= S_FEED;
                        if (rd_cnt < CNT_N) begin
                            o_buf_rd_en <= 1'b1;
                            o_buf_addr  <= rd_cnt[ADDR_BW-1:0];
                            rd_cnt      <= rd_cnt + 1'b1;
                        end else begin
                            o_buf_rd_en <= 1'b0;
                        end
                        // rd_vld marks the cycle read data is on i_buf_rd_data
                        rd_vld  <= o_buf_rd_en;
                        o_fc_ce <= rd_vld;
                        if (rd_vld) begin
                            o_fc_data <= i_buf_rd_data;
                            ce_cnt    <= ce_cnt + 1'b1;
                        end
                        if (o_fc_ce && ce_cnt == CNT_N) begin
                            state   <= S_WAIT;
                            o_fc_ce <= 1'b0;
`ifdef FC_CTRL_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                        end
                    end
                    S_WAIT: begin
                        if (i_fc_end) begin
                            state    <= S_DONE;
                            o_result <= i_fc_data;
                            o_done   <= 1'b1;
                            o_irq    <= 1'b1;
                            o_busy   <= 1'b0;
`ifdef FC_CTRL_TIMEOUT_EN
                        end else if (wait_cnt == WAIT_LAST) begin
                            state           <= S_DONE;
                            o_result        <= 4'hF;
                            o_timeout       <= 1'b1;
                            o_done          <= 1'b1;
                            o_irq           <= 1'b1;
                            o_busy          <= 1'b0;
                            o_fc_user_reset <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
`endif
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fc_ctrl.sv
// tb/tb_fc_ctrl.sv - self-checking bench for fc_ctrl against a cycle-schedule reference model
module tb_fc_ctrl;

    localparam int I_BW = 16;
    localparam int N    = 192;
    localparam int TO   = 64;

    logic            clk = 1'b0;
    logic            global_rst_n;
    logic            i_start, i_abort, i_done_clr;
    logic            o_busy, o_done, o_irq, o_timeout;
    logic [3:0]      o_result;
    logic            o_buf_rd_en;
    logic [7:0]      o_buf_addr;
    logic [I_BW-1:0] i_buf_rd_data;
    logic            o_fc_ce;
    logic [I_BW-1:0] o_fc_data;
    logic            o_fc_user_reset;
    logic            i_fc_end;
    logic [3:0]      i_fc_data;

    always #5 clk = ~clk;

    fc_ctrl dut (
        .clk             (clk),
        .global_rst_n    (global_rst_n),
        .i_start         (i_start),
        .i_abort         (i_abort),
        .i_done_clr      (i_done_clr),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_irq           (o_irq),
        .o_result        (o_result),
        .o_timeout       (o_timeout),
        .o_buf_rd_en     (o_buf_rd_en),
        .o_buf_addr      (o_buf_addr),
        .i_buf_rd_data   (i_buf_rd_data),
        .o_fc_ce         (o_fc_ce),
        .o_fc_data       (o_fc_data),
        .o_fc_user_reset (o_fc_user_reset),
        .i_fc_end        (i_fc_end),
        .i_fc_data       (i_fc_data)
    );

    logic [I_BW-1:0] mem [N];
    always @(posedge clk) if (o_buf_rd_en) i_buf_rd_data <= mem[o_buf_addr];

    int         vectors    = 0;
    int         miscompares = 0;
    logic [3:0] last_result = 4'h0;

    // One start-to-finish run; expected outputs come from the cycle schedule counted from the start cycle (0).
    task automatic run_case(input int abort_at, input int extra_start_at, input int fc_end_at,
                            input logic [3:0] cls, input bit clr_at_done, input bit start_with_abort,
                            input bit seq_data);
        int         done_cyc;
        bit         timed_out;
        logic [6:0] obs, exp;
        logic [3:0] exp_res;
        timed_out = (fc_end_at < 0);
        done_cyc  = timed_out ? 196 + TO : fc_end_at + 1;
        for (int k = 0; k < N; k++) mem[k] = seq_data ? I_BW'(k) : I_BW'($urandom);
        @(posedge clk); #1;
        i_start = 1'b1;
        for (int c = 1; c < 1000; c++) begin
            @(posedge clk); #1;
            i_start = 1'b0; i_abort = 1'b0; i_done_clr = 1'b0;
            if (c == extra_start_at) i_start = 1'b1;
            if (c == abort_at) begin
                i_abort = 1'b1;
                if (start_with_abort) i_start = 1'b1;
            end
            if (c == fc_end_at) begin
                i_fc_end  = 1'b1;
                i_fc_data = cls;
            end
            if (clr_at_done && c == done_cyc) i_done_clr = 1'b1;
            @(negedge clk);
            obs = {o_busy, o_buf_rd_en, o_fc_ce, o_irq, o_done, o_timeout, o_fc_user_reset};
            if (abort_at > 0 && c > abort_at) begin
                exp = {6'b0, (c == abort_at + 1)};
                vectors++;
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL abort_ctl c=%0d got=%b exp=%b", c, obs, exp);
                end
                vectors++;
                if (o_result !== last_result) begin
                    miscompares++;
                    $display("FAIL abort_result c=%0d got=%h exp=%h", c, o_result, last_result);
                end
                if (c == abort_at + 2) break;
            end else begin
                exp = {(c < done_cyc), (c >= 2 && c <= N + 1), (c >= 4 && c <= N + 3), (c == done_cyc),
                       (c >= done_cyc), (timed_out && c >= done_cyc), (c == 1 || (timed_out && c == done_cyc))};
                vectors++;
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL ctl c=%0d got=%b exp=%b", c, obs, exp);
                end
                if (c >= 2 && c <= N + 1) begin
                    vectors++;
                    if (o_buf_addr !== 8'(c - 2)) begin
                        miscompares++;
                        $display("FAIL addr c=%0d got=%0d exp=%0d", c, o_buf_addr, c - 2);
                    end
                end
                if (c >= 4 && c <= N + 3) begin
                    vectors++;
                    if (o_fc_data !== mem[c - 4]) begin
                        miscompares++;
                        $display("FAIL fc_data c=%0d got=%h exp=%h", c, o_fc_data, mem[c - 4]);
                    end
                end
                if (c >= done_cyc) begin
                    exp_res = timed_out ? 4'hF : cls;
                    vectors++;
                    if (o_result !== exp_res) begin
                        miscompares++;
                        $display("FAIL result c=%0d got=%h exp=%h", c, o_result, exp_res);
                    end
                end
                if (c == done_cyc + 1) begin
                    last_result = timed_out ? 4'hF : cls;
                    break;
                end
            end
        end
        @(posedge clk); #1;
        i_start = 1'b0; i_abort = 1'b0; i_done_clr = 1'b0; i_fc_end = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        vectors++;
        if ({o_busy, o_done, o_irq, o_timeout, o_buf_rd_en, o_fc_ce, o_fc_user_reset, o_result, o_buf_addr, o_fc_data} !== '0) begin
            miscompares++;
            $display("FAIL %s got busy=%b done=%b irq=%b to=%b rd=%b ce=%b ur=%b res=%h addr=%0d data=%h exp all zero",
                     tag, o_busy, o_done, o_irq, o_timeout, o_buf_rd_en, o_fc_ce, o_fc_user_reset, o_result, o_buf_addr, o_fc_data);
        end
    endtask

    task automatic test_reset();
        global_rst_n = 1'b0;
        i_start = 1'b0; i_abort = 1'b0; i_done_clr = 1'b0; i_fc_end = 1'b0; i_fc_data = 4'h0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset_hold");
        global_rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("reset_release");
    endtask

    task automatic test_reset_mid_feed();
        for (int k = 0; k < N; k++) mem[k] = I_BW'($urandom);
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        vectors++;
        if (o_fc_ce !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_feed_ce got=%b exp=1", o_fc_ce);
        end
        #1 global_rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(posedge clk); #1 global_rst_n = 1'b1;
        @(posedge clk); #1 check_all_zero("post_reset_idle");
        last_result = 4'h0;
    endtask

    task automatic test_nominal();
        run_case(-1, -1, 210, 4'h7, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++)
            run_case(-1, int'($urandom_range(2, 200)), int'($urandom_range(196, 240)),
                     4'($urandom), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        run_case(50, -1, 999, 4'h0, 1'b0, 1'b0, 1'b0);
        run_case(-1, -1, 205, 4'h3, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++)
            run_case(int'($urandom_range(1, 230)), -1, 999, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_same_cycle();
        run_case(int'($urandom_range(1, 195)), -1, 999, 4'h0, 1'b0, 1'b1, 1'b0);
        run_case(-1, -1, int'($urandom_range(196, 220)), 4'($urandom), 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1 i_done_clr = 1'b1;
        @(posedge clk); #1 i_done_clr = 1'b0;
        vectors++;
        if (o_done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_clr_idle got=%b exp=0", o_done);
        end
    endtask

`ifdef FC_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        run_case(-1, -1, -1, 4'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1 i_done_clr = 1'b1;
        @(posedge clk); #1 i_done_clr = 1'b0;
        vectors++;
        if ({o_done, o_timeout} !== 2'b00) begin
            miscompares++;
            $display("FAIL timeout_clr got=%b exp=00", {o_done, o_timeout});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_reset_mid_feed();
        test_nominal();
        test_back_to_back();
        test_abort();
        test_same_cycle();
`ifdef FC_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fc_ctrl.md
Name: fc_ctrl

Overview:
- Sequencer for the fully-connected classifier stage.
- Takes a start command from the AXI4-Lite register block, clears the FC datapath, then streams I_SIZE*I_SIZE*CI pooled features from the feature buffer into the datapath.
- Waits for the datapath's end-of-inference flag, latches the 4-bit class, and reports done/irq back to the register block.
- Sits between the pooling feature buffer, the FC datapath and the register block.

Parameters:
- I_BW, 16: feature word width.
- I_SIZE, 4: feature map side length.
- CI, 12: feature channels.
- TIMEOUT_CYC, 64: maximum WAIT cycles before a timeout (used only with the optional feature).
- Derived localparams: N = I_SIZE*I_SIZE*CI (192); ADDR_BW = clog2(N).

Ports:
- clk  input  1  single clock, rising edge.
- global_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  start pulse from register block.
- i_abort  input  1  abort pulse from register block.
- i_done_clr  input  1  clears sticky done/timeout.
- o_busy  output  1  high from accepted start until DONE/abort.
- o_done  output  1  sticky completion flag.
- o_irq  output  1  one-cycle completion pulse.
- o_result  output  4  latched class index.
- o_timeout  output  1  sticky timeout flag.
- o_buf_rd_en  output  1  feature buffer read enable.
- o_buf_addr  output  ADDR_BW  feature buffer read address.
- i_buf_rd_data  input  I_BW  read data, valid exactly 1 cycle after o_buf_rd_en.
- o_fc_ce  output  1  datapath accumulate enable.
- o_fc_data  output  I_BW  datapath input feature.
- o_fc_user_reset  output  1  datapath synchronous clear.
- i_fc_end  input  1  datapath end flag; level, stays high until cleared.
- i_fc_data  input  4  datapath class output.

Behaviour:
- Reset: state IDLE. All outputs are 0: o_buf_addr=0, o_result=0, o_busy=0, o_done=0, o_irq=0, o_timeout=0, o_fc_ce=0, o_fc_data=0, o_fc_user_reset=0.
- IDLE:
  - i_start=1 moves to CLEAR, sets o_busy=1, and clears o_done and o_timeout.
  - i_start while busy is ignored.
- CLEAR (1 cycle): o_fc_user_reset=1, read counter=0, ce counter=0, then go to FEED.
- FEED read side:
  - One read per cycle: o_buf_rd_en=1, o_buf_addr = 0..N-1 ascending.
  - Reads stop after address N-1; no wrap.
- FEED datapath side:
  - Data is registered: o_fc_ce=1 and o_fc_data=i_buf_rd_data in the cycle after data returns, i.e. 2 cycles after the matching rd_en.
  - Exactly N o_fc_ce cycles, contiguous, in address order.
  - o_fc_ce is never high outside FEED.
- FEED exit: go to WAIT the cycle after the N-th o_fc_ce. o_fc_ce=0 from then on.
- FEED timing with start sampled at cycle 0:
  - CLEAR at cycle 1.
  - rd_en in cycles 2..193.
  - o_fc_ce in cycles 4..195.
  - WAIT from cycle 196.
- WAIT: o_fc_ce held 0. On the first cycle i_fc_end=1, set o_result=i_fc_data and go to DONE.
- DONE (1 cycle): o_done=1 (sticky), o_irq=1 for this cycle only, o_busy=0, then go to IDLE.
- o_done/o_timeout clear:
  - Cleared by i_done_clr or by an accepted start.
  - If set and i_done_clr occur in the same cycle, set wins.
- Abort:
  - i_abort in any non-IDLE state goes to IDLE next cycle, with o_fc_user_reset=1 for that one cycle.
  - Any in-flight read data is discarded and o_fc_ce is forced 0.
  - o_busy=0; no irq; o_done and o_result unchanged.
  - i_abort in IDLE has no effect.
  - Abort beats start when both arrive in the same cycle.
- Counters: the read and ce counters are ADDR_BW+1 bits, so N fits without overflow.

Optional Feature:
- Macro FC_CTRL_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter runs while in WAIT.
  - If TIMEOUT_CYC cycles pass with no i_fc_end, go to DONE with o_result=4'hF, o_timeout=1 (sticky), o_done=1, o_irq pulse, and o_fc_user_reset=1 during the DONE cycle.
  - If i_fc_end arrives on the same cycle the counter expires, the normal result wins.
- Not defined: WAIT waits indefinitely and o_timeout is tied to 0.

Test Plan:
- Reset mid-FEED: assert global_rst_n=0 at cycle 100 -> all outputs 0 immediately (asynchronous); IDLE after release.
- Nominal: buffer[k]=k, start at cycle 0 -> rd_en at 2..193, o_fc_ce at 4..195 with o_fc_data=0..191; model raises i_fc_end with i_fc_data=7 at cycle 210 -> o_result=7, o_done=1 and o_irq=1 at cycle 211, o_busy=0.
- Back-to-back runs: start during busy is ignored (ce count stays 192); start after DONE clears o_done and emits one o_fc_user_reset pulse before the new feed.
- Abort at cycle 50 -> o_fc_ce=0 from cycle 51, one o_fc_user_reset pulse, no irq, o_done stays 0; a restart then completes normally with exactly 192 ce cycles.
- Same-cycle events: i_abort+i_start in BUSY -> abort wins; i_done_clr in the same cycle as DONE -> o_done=1.
- FC_CTRL_TIMEOUT_EN with TIMEOUT_CYC=64 and i_fc_end held 0 -> DONE at WAIT cycle 64, o_result=4'hF, o_timeout=1, single irq; i_done_clr clears both flags.
